// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcode constants and operand-usage decode for the issue path.
package cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned IDX_W     = $clog2(REG_COUNT);
  localparam int unsigned OP_W      = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OP_W-1:0] OP_INC = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00101;
  localparam logic [OP_W-1:0] OP_XOR = 5'b00110;
  localparam logic [OP_W-1:0] OP_MUL = 5'b00111;

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    return op inside {OP_INC, OP_ADD, OP_XOR, OP_MUL};
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_XOR, OP_MUL};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 16x8 register file: two combinational read ports with write-to-read bypass,
// one synchronous write port, r0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage ahead of the ALU: pending-register scoreboard, hazard stall
// and a single output register holding the ALU inputs.
module operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_aluOp,
  input  logic [IDX_W-1:0]  in_rs1,
  input  logic [IDX_W-1:0]  in_rs2,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic              in_regWrite,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   aluOp,
  output logic [DATA_W-1:0] srcA,
  output logic [DATA_W-1:0] srcB,
  output logic [IDX_W-1:0]  out_rd,
  output logic              out_regWrite
);

  logic [DATA_W-1:0]    rd_a, rd_b, op_a, op_b;
  logic [REG_COUNT-1:0] pend_q, pend_d, wb_clr, iss_set, pend_eff;
  logic                 use_a, use_b, hazard, slot_free, accept;

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (in_rs1),
    .raddr_b (in_rs2),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_rd] = 1'b1;
    // A write-back landing this cycle already resolves its register.
    pend_eff  = pend_q & ~wb_clr;
    use_a     = uses_rs1(in_aluOp);
    use_b     = uses_rs2(in_aluOp);
    hazard    = (use_a && pend_eff[in_rs1]) || (use_b && pend_eff[in_rs2]) ||
                (in_regWrite && pend_eff[in_rd]);
    slot_free = !out_valid || out_ready;
    in_ready  = rst || (slot_free && !hazard);
    accept    = in_valid && in_ready && !rst;
    op_a      = use_a ? rd_a : '0;
    op_b      = use_b ? rd_b : '0;
    iss_set   = '0;
    if (accept && in_regWrite) iss_set[in_rd] = 1'b1;
    // Set after clear: a new writer wins over a same-cycle write-back.
    pend_d    = pend_eff | iss_set;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      out_valid    <= 1'b0;
      aluOp        <= '0;
      srcA         <= '0;
      srcB         <= '0;
      out_rd       <= '0;
      out_regWrite <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        out_valid    <= 1'b1;
        aluOp        <= in_aluOp;
        srcA         <= op_a;
        srcB         <= op_b;
        out_rd       <= in_rd;
        out_regWrite <= in_regWrite;
      end else if (slot_free) begin
        out_valid <= 1'b0;
        aluOp     <= OP_NOP;
      end
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Directed scenarios plus randomized traffic against a behavioural model of the
// register file, pending set and single output slot.
module tb_operand_stage;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, in_regWrite, wb_en, out_valid, out_ready, out_regWrite;
  logic [4:0] in_aluOp, aluOp;
  logic [3:0] in_rs1, in_rs2, in_rd, wb_rd, out_rd;
  logic [7:0] wb_data, srcA, srcB;

  int n_checks = 0;
  int n_bad    = 0;

  // Behavioural model state
  logic [7:0] m_regs [16];
  bit         m_pend [16];
  bit         m_valid, m_rw;
  logic [4:0] m_op;
  logic [7:0] m_a, m_b;
  logic [3:0] m_rd;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluOp     (in_aluOp),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_regWrite  (in_regWrite),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluOp        (aluOp),
    .srcA         (srcA),
    .srcB         (srcB),
    .out_rd       (out_rd),
    .out_regWrite (out_regWrite)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_use1(input logic [4:0] op);
    return op == 5'd4 || op == 5'd5 || op == 5'd6 || op == 5'd7;
  endfunction

  function automatic bit m_use2(input logic [4:0] op);
    return op == 5'd5 || op == 5'd6 || op == 5'd7;
  endfunction

  function automatic bit m_busy(input logic [3:0] r, input logic we, input logic [3:0] wr);
    return m_pend[r] && !(we && wr == r);
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] r, input logic we,
                                        input logic [3:0] wr, input logic [7:0] wd);
    if (r == 4'd0) return 8'h00;
    if (we && wr == r) return wd;
    return m_regs[r];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_valid = 1'b0; m_op = 5'd0; m_a = 8'h00; m_b = 8'h00; m_rd = 4'd0; m_rw = 1'b0;
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
  task automatic step(input logic v, input logic [4:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] d, input logic rw,
                      input logic we, input logic [3:0] wr, input logic [7:0] wd,
                      input logic ordy, input logic r);
    bit slot, haz, rdy, acc;
    @(negedge clk);
    rst = r; in_valid = v; in_aluOp = op; in_rs1 = a; in_rs2 = b; in_rd = d;
    in_regWrite = rw; wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
    #1;
    slot = !m_valid || ordy;
    haz  = (m_use1(op) && m_busy(a, we, wr)) || (m_use2(op) && m_busy(b, we, wr)) ||
           (rw && m_busy(d, we, wr));
    rdy  = r || (slot && !haz);
    check_eq("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    if (r) begin
      m_clear();
    end else begin
      acc = v && rdy;
      if (acc) begin
        m_valid = 1'b1; m_op = op; m_rd = d; m_rw = rw;
        m_a = m_use1(op) ? m_read(a, we, wr, wd) : 8'h00;
        m_b = m_use2(op) ? m_read(b, we, wr, wd) : 8'h00;
      end else if (slot) begin
        m_valid = 1'b0; m_op = 5'd0;
      end
      if (we && wr != 4'd0) m_regs[wr] = wd;
      if (we) m_pend[wr] = 1'b0;
      if (acc && rw && d != 4'd0) m_pend[d] = 1'b1;
    end
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("aluOp", 32'(aluOp), 32'(m_op));
    if (m_valid || r) begin
      check_eq("srcA", 32'(srcA), 32'(m_a));
      check_eq("srcB", 32'(srcB), 32'(m_b));
      check_eq("out_rd", 32'(out_rd), 32'(m_rd));
      check_eq("out_regWrite", 32'(out_regWrite), 32'(m_rw));
    end
  endtask

  task automatic idle(input logic we, input logic [3:0] wr, input logic [7:0] wd);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, we, wr, wd, 1'b1, 1'b0);
  endtask

  initial begin
    logic [4:0] ops [5];
    logic [4:0] op;
    ops[0] = 5'd0; ops[1] = 5'd4; ops[2] = 5'd5; ops[3] = 5'd6; ops[4] = 5'd7;
    m_clear();
    rst = 1'b1; in_valid = 1'b0; in_aluOp = 5'd0; in_rs1 = 4'd0; in_rs2 = 4'd0;
    in_rd = 4'd0; in_regWrite = 1'b0; wb_en = 1'b0; wb_rd = 4'd0; wb_data = 8'h00;
    out_ready = 1'b1;

    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    check_eq("reset_valid", 32'(out_valid), 32'd0);

    // Basic add
    idle(1'b1, 4'd3, 8'h05);
    idle(1'b1, 4'd4, 8'h07);
    step(1'b1, 5'd5, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("add_op", 32'(aluOp), 32'h05);
    check_eq("add_a", 32'(srcA), 32'h05);
    check_eq("add_b", 32'(srcB), 32'h07);
    check_eq("add_rd", 32'(out_rd), 32'd5);

    // RAW on r5, released by a same-cycle write-back
    step(1'b1, 5'd4, 4'd5, 4'd0, 4'd8, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("raw_stall", 32'(out_valid), 32'd0);
    step(1'b1, 5'd4, 4'd5, 4'd0, 4'd8, 1'b1, 1'b1, 4'd5, 8'h0C, 1'b1, 1'b0);
    check_eq("raw_bypass", 32'(srcA), 32'h0C);

    // Backpressure
    step(1'b1, 5'd5, 4'd3, 4'd4, 4'd9, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd6, 4'd3, 4'd4, 4'd10, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_eq("bp_hold_rd", 32'(out_rd), 32'd9);
    step(1'b1, 5'd6, 4'd3, 4'd4, 4'd10, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("bp_release", 32'(out_rd), 32'd10);

    // r0 stays zero and never pends
    idle(1'b1, 4'd0, 8'hFF);
    step(1'b1, 5'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 5'd4, 4'd0, 4'd0, 4'd11, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("r0_nostall", 32'(out_rd), 32'd11);
    check_eq("r0_zero", 32'(srcA), 32'd0);

    // WAW with simultaneous clear: pending must survive
    step(1'b1, 5'd4, 4'd1, 4'd0, 4'd6, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 5'd6, 4'd3, 4'd4, 4'd6, 1'b1, 1'b1, 4'd6, 8'h11, 1'b1, 1'b0);
    step(1'b1, 5'd4, 4'd6, 4'd0, 4'd12, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("waw_pend", 32'(out_valid), 32'd0);

    // Reset mid-operation with r7 pending and a held instruction
    step(1'b1, 5'd4, 4'd1, 4'd0, 4'd7, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 8'h33, 1'b0, 1'b1);
    step(1'b1, 5'd4, 4'd7, 4'd0, 4'd13, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    check_eq("rst_accept", 32'(out_valid), 32'd1);
    check_eq("rst_srcA", 32'(srcA), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      op = (($urandom_range(0, 5)) == 5) ? 5'($urandom_range(0, 31))
                                         : ops[$urandom_range(0, 4)];
      step(1'($urandom_range(0, 3) != 0), op, 4'($urandom_range(0, 7)),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4),
           4'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
